// File: rtl/image_blit_controller.sv
// image_blit_controller: centred ROM->frame-buffer blit with x1/x2/x4 upscale.
// Optional clear pass before the copy is enabled by defining BLIT_CLEAR_EN.
module image_blit_controller #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int FB_W    = 640,
    parameter int FB_H    = 480,
    parameter int DATA_W  = 8,
    parameter int ROM_AW  = 15,
    parameter int RAM_AW  = 19,
    parameter int ROM_LAT = 1
`ifdef BLIT_CLEAR_EN
   ,parameter logic [DATA_W-1:0] BG_COLOR = '0
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        scale,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_COPY  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int  FB_N = FB_W * FB_H;
    localparam bit  FIT1 = (2 * IMG_W <= FB_W) && (2 * IMG_H <= FB_H);
    localparam bit  FIT2 = (4 * IMG_W <= FB_W) && (4 * IMG_H <= FB_H);
    localparam int  MAX_SHIFT = FIT2 ? 2 : (FIT1 ? 1 : 0);

    localparam int OX0 = (FB_W - IMG_W) / 2;
    localparam int OY0 = (FB_H - IMG_H) / 2;
    localparam int OX1 = (FB_W - 2 * IMG_W) / 2;
    localparam int OY1 = (FB_H - 2 * IMG_H) / 2;
    localparam int OX2 = (FB_W - 4 * IMG_W) / 2;
    localparam int OY2 = (FB_H - 4 * IMG_H) / 2;

    if (IMG_W > FB_W || IMG_H > FB_H) begin : g_err_fit
        $error("image_blit_controller: image larger than frame buffer");
    end
    if ((64'd1 << ROM_AW) < 64'(IMG_W * IMG_H)) begin : g_err_rom
        $error("image_blit_controller: ROM_AW too small");
    end
    if ((64'd1 << RAM_AW) < 64'(FB_N)) begin : g_err_ram
        $error("image_blit_controller: RAM_AW too small");
    end
    if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_err_lat
        $error("image_blit_controller: ROM_LAT must be 1..3");
    end

    logic [2:0]        state_q, state_d;
    logic [1:0]        shift_q, shift_d;
    logic [RAM_AW-1:0] dx_q, dx_d;
    logic [RAM_AW-1:0] dy_q, dy_d;
    logic [RAM_AW-1:0] ox_q, ox_d;
    logic [RAM_AW-1:0] oy_q, oy_d;
    logic [RAM_AW-1:0] xl_q, xl_d;
    logic [RAM_AW-1:0] yl_q, yl_d;
    logic [RAM_AW-1:0] apipe_q [ROM_LAT];
    logic [RAM_AW-1:0] apipe_d [ROM_LAT];
    logic [ROM_LAT-1:0] vpipe_q, vpipe_d;
    logic [ROM_LAT-1:0] lpipe_q, lpipe_d;
`ifdef BLIT_CLEAR_EN
    logic [RAM_AW-1:0] clr_q, clr_d;
`endif

    logic [1:0]        req_shift;
    logic [1:0]        new_shift;
    logic              vld_in;
    logic              last_in;
    logic [RAM_AW-1:0] dest;
    logic [ROM_AW-1:0] src;

    // Source pixel and destination address for the current raster position
    always_comb begin
        dest = (dy_q + oy_q) * RAM_AW'(FB_W) + (dx_q + ox_q);
        src  = ROM_AW'(dy_q >> shift_q) * ROM_AW'(IMG_W)
             + ROM_AW'(dx_q >> shift_q);
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        xl_d      = xl_q;
        yl_d      = yl_q;
`ifdef BLIT_CLEAR_EN
        clr_d     = clr_q;
`endif
        vld_in    = 1'b0;
        last_in   = 1'b0;
        req_shift = 2'd0;
        new_shift = 2'd0;

        case (scale)
            2'd1:    req_shift = 2'd1;
            2'd2:    req_shift = 2'd2;
            default: req_shift = 2'd0;
        endcase
        new_shift = (req_shift > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : req_shift;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    shift_d = new_shift;
                    dx_d    = '0;
                    dy_d    = '0;
                    case (new_shift)
                        2'd1: begin
                            ox_d = RAM_AW'(OX1);
                            oy_d = RAM_AW'(OY1);
                            xl_d = RAM_AW'(2 * IMG_W - 1);
                            yl_d = RAM_AW'(2 * IMG_H - 1);
                        end
                        2'd2: begin
                            ox_d = RAM_AW'(OX2);
                            oy_d = RAM_AW'(OY2);
                            xl_d = RAM_AW'(4 * IMG_W - 1);
                            yl_d = RAM_AW'(4 * IMG_H - 1);
                        end
                        default: begin
                            ox_d = RAM_AW'(OX0);
                            oy_d = RAM_AW'(OY0);
                            xl_d = RAM_AW'(IMG_W - 1);
                            yl_d = RAM_AW'(IMG_H - 1);
                        end
                    endcase
`ifdef BLIT_CLEAR_EN
                    clr_d   = '0;
                    state_d = S_CLEAR;
`else
                    state_d = S_COPY;
`endif
                end
            end
`ifdef BLIT_CLEAR_EN
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == RAM_AW'(FB_N - 1)) begin
                    state_d = S_COPY;
                end
            end
`endif
            S_COPY: begin
                vld_in = 1'b1;
                if (dx_q == xl_q) begin
                    dx_d = '0;
                    if (dy_q == yl_q) begin
                        last_in = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (lpipe_q[ROM_LAT-1]) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Destination address travels alongside the ROM read
    always_comb begin
        apipe_d[0] = dest;
        vpipe_d[0] = vld_in;
        lpipe_d[0] = last_in;
        for (int i = 1; i < ROM_LAT; i++) begin
            apipe_d[i] = apipe_q[i-1];
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            vpipe_q <= '0;
            lpipe_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                apipe_q[i] <= '0;
            end
`ifdef BLIT_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            vpipe_q <= vpipe_d;
            lpipe_q <= lpipe_d;
            for (int i = 0; i < ROM_LAT; i++) begin
                apipe_q[i] <= apipe_d[i];
            end
`ifdef BLIT_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    always_comb begin
        rom_addr = (state_q == S_COPY) ? src : '0;
        ram_wren = vpipe_q[ROM_LAT-1];
        ram_addr = vpipe_q[ROM_LAT-1] ? apipe_q[ROM_LAT-1] : '0;
        ram_data = vpipe_q[ROM_LAT-1] ? rom_data : '0;
`ifdef BLIT_CLEAR_EN
        if (state_q == S_CLEAR) begin
            ram_wren = 1'b1;
            ram_addr = clr_q;
            ram_data = BG_COLOR;
        end
`endif
        // busy drops in the cycle the final pixel is on the bus
        busy = (state_q == S_CLEAR) || (state_q == S_COPY)
            || ((state_q == S_DRAIN) && !lpipe_q[ROM_LAT-1]);
        done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_image_blit_controller.sv
// tb_image_blit_controller: directed test of the blit on a 16x12 image into
// a 64x48 frame buffer, ROM latency 1 and 3 instances run side by side.
module tb_image_blit_controller;

    localparam int IW = 16;
    localparam int IH = 12;
    localparam int FW = 64;
    localparam int FH = 48;
    localparam int FN = FW * FH;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] scale;

    logic [7:0]  rom_addr [2];
    logic [7:0]  rom_data [2];
    logic [11:0] ram_addr [2];
    logic [7:0]  ram_data [2];
    logic        ram_wren [2];
    logic        busy     [2];
    logic        done     [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cur_sc   = 0;
    bit clr      = 1'b1;

    int nwr     [2];
    int nbad    [2];
    int nb0     [2];
    int first_a [2];
    int first_c [2];
    int last_a  [2];
    int last_d  [2];
    bit seen    [2];
    int cov     [2][FN];
    int mem     [2][FN];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] dl [3];

        image_blit_controller #(
            .IMG_W(IW), .IMG_H(IH), .FB_W(FW), .FB_H(FH),
            .DATA_W(8), .ROM_AW(8), .RAM_AW(12), .ROM_LAT(LAT)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start),
            .scale    (scale),
            .rom_addr (rom_addr[g]),
            .rom_data (rom_data[g]),
            .ram_addr (ram_addr[g]),
            .ram_data (ram_data[g]),
            .ram_wren (ram_wren[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );

        // ROM model: content equals address, fixed read latency
        always @(posedge clk) begin
            dl[0] <= rom_addr[g];
            dl[1] <= dl[0];
            dl[2] <= dl[1];
        end
        assign rom_data[g] = dl[LAT-1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pix(input int a, input int sc);
        int sh, w, h, ox, oy, x, y;
        sh = (sc == 1) ? 1 : ((sc == 2) ? 2 : 0);
        w  = IW << sh;
        h  = IH << sh;
        ox = (FW - w) / 2;
        oy = (FH - h) / 2;
        x  = a % FW;
        y  = a / FW;
        if (x < ox || x >= ox + w || y < oy || y >= oy + h) return -1;
        return ((((y - oy) >> sh) * IW) + ((x - ox) >> sh)) & 255;
    endfunction

    initial forever begin
        @(negedge clk);
        if (clr) begin
            for (int g = 0; g < 2; g++) begin
                nwr[g] = 0; nbad[g] = 0; nb0[g] = 0; seen[g] = 1'b0;
                first_a[g] = -1; first_c[g] = -1;
                last_a[g] = -1; last_d[g] = -1;
                for (int a = 0; a < FN; a++) begin
                    cov[g][a] = 0;
                    mem[g][a] = -1;
                end
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (ram_wren[g] === 1'b1) begin
                    int a;
                    a = int'(ram_addr[g]);
                    if (!seen[g]) begin
                        seen[g]    = 1'b1;
                        first_a[g] = a;
                        first_c[g] = cyc;
                    end
                    last_a[g] = a;
                    last_d[g] = int'(ram_data[g]);
                    nwr[g]++;
                    if (busy[g] !== 1'b1) nb0[g]++;
                    if (a >= FN) begin
                        nbad[g]++;
                    end else begin
                        cov[g][a]++;
                        mem[g][a] = int'(ram_data[g]);
                        if (int'(ram_data[g]) != exp_pix(a, cur_sc)) nbad[g]++;
                    end
                end
            end
        end
    end

    task automatic clear_stats(input int sc);
        cur_sc = sc;
        clr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input int sc, input bit poke, output int t0);
        int n;
        clear_stats(sc);
        scale = 2'(sc);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!(done[0] && done[1]) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", int'(done[0] && done[1]), 1);
    endtask

    task automatic end_state(input string tag);
        check({tag, "_busy"}, int'(busy[0]), 0);
        check({tag, "_done"}, int'(done[0]), 1);
        check({tag, "_wren"}, int'(ram_wren[0]), 0);
    endtask

    initial begin
        int t0, n, holes;
        reset_n = 1'b0;
        start   = 1'b0;
        scale   = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);
        check("rst_wren", int'(ram_wren[0]), 0);
        check("rst_ram_addr", int'(ram_addr[0]), 0);
        check("rst_rom_addr", int'(rom_addr[0]), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run(0, 1'b0, t0);
        check("s0_nwr", nwr[0], 192);
        check("s0_nwr_lat3", nwr[1], 192);
        check("s0_first", first_a[0], 1176);
        check("s0_first_data", mem[0][1176], 0);
        check("s0_last", last_a[0], 1895);
        check("s0_last_data", last_d[0], 191);
        check("s0_lat1_first_cyc", first_c[0] - t0, 2);
        check("s0_lat3_first_cyc", first_c[1] - t0, 4);
        check("s0_bad", nbad[0], 0);
        check("s0_bad_lat3", nbad[1], 0);
        check("s0_busy_low_wr", nb0[0], 1);
        check("s0_busy_low_wr3", nb0[1], 1);
        end_state("s0");

        run(1, 1'b0, t0);
        check("s1_nwr", nwr[0], 768);
        check("s1_first", first_a[0], 784);
        check("s1_last", last_a[0], 2287);
        check("s1_last_data", last_d[0], 191);
        check("s1_px784", mem[0][784], 0);
        check("s1_px785", mem[0][785], 0);
        check("s1_px848", mem[0][848], 0);
        check("s1_px786", mem[0][786], 1);
        check("s1_bad", nbad[0], 0);
        check("s1_bad_lat3", nbad[1], 0);
        end_state("s1");

        run(2, 1'b0, t0);
        holes = 0;
        for (int a = 0; a < FN; a++) if (cov[0][a] != 1) holes++;
        check("s2_nwr", nwr[0], 3072);
        check("s2_cover", holes, 0);
        check("s2_first", first_a[0], 0);
        check("s2_last", last_a[0], 3071);
        check("s2_px3", mem[0][3], 0);
        check("s2_px4", mem[0][4], 1);
        check("s2_px3071", mem[0][3071], 191);
        check("s2_bad", nbad[0], 0);
        check("s2_bad_lat3", nbad[1], 0);
        end_state("s2");

        run(3, 1'b1, t0);
        check("s3_nwr", nwr[0], 192);
        check("s3_nwr_lat3", nwr[1], 192);
        check("s3_first", first_a[0], 1176);
        check("s3_last", last_a[0], 1895);
        check("s3_bad", nbad[0], 0);
        end_state("s3");

        clear_stats(0);
        scale = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (nwr[0] < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", int'(nwr[0] >= 100), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_wren", int'(ram_wren[0]), 0);
        check("abort_wren3", int'(ram_wren[1]), 0);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_done", int'(done[0]), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run(0, 1'b0, t0);
        check("restart_first", first_a[0], 1176);
        check("restart_nwr", nwr[0], 192);
        check("restart_bad", nbad[0], 0);
        end_state("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
